// File: rtl/key_display_pkg.sv
// Shared constants and lookups for the two-digit keypad display controller:
// hex-to-segment table, blank pattern and keypad row/column to hex decode.
package key_display_pkg;

    // Active-low segment pattern {g,f,e,d,c,b,a} with every segment off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Keypad legend indexed by {row, col}.
    localparam logic [3:0] KEY_HEX [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'h0) && ((v & (v - 4'h1)) == 4'h0);
    endfunction

    // Only meaningful for one-hot input; callers qualify with is_onehot4.
    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] key_to_hex(input logic [7:0] rc);
        return KEY_HEX[{onehot_idx(rc[7:4]), onehot_idx(rc[3:0])}];
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational hex to active-low 7-segment decoder.
module seg_decode
    import key_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/key_display_ctrl.sv
// Keypad capture and two-digit multiplexed display controller.
// Optional feature: define KEY_DISPLAY_BLANK_EN to blank digits that have
// not yet received a key since reset.
module key_display_ctrl
    import key_display_pkg::*;
#(
    parameter int DIV_W = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rc,
    input  logic       en,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    logic [DIV_W-1:0] div_cnt;
    logic             sel;
    logic             en_q;
    logic             en_seen_low;
    logic             capture;
    logic             blank_win;
    logic [3:0]       mux_hex;
    logic [6:0]       mux_seg;
    logic [6:0]       seg_next;

`ifdef KEY_DISPLAY_BLANK_EN
    logic valid_new;
    logic valid_old;
    logic mux_valid;
`endif

    // Capture qualification: fresh rising edge of en with a clean one-hot row and column.
    always_comb begin
        capture   = en && !en_q && en_seen_low &&
                    is_onehot4(rc[7:4]) && is_onehot4(rc[3:0]);
        blank_win = (div_cnt == '1) || (div_cnt < DIV_W'(4));
        mux_hex   = sel ? digit_old : digit_new;
`ifdef KEY_DISPLAY_BLANK_EN
        mux_valid = sel ? valid_old : valid_new;
        seg_next  = mux_valid ? mux_seg : SEG_BLANK;
`else
        seg_next  = mux_seg;
`endif
    end

    seg_decode u_seg_decode (
        .hex (mux_hex),
        .seg (mux_seg)
    );

    // Edge detect and digit shift register; en_seen_low blocks a held key across reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q        <= 1'b0;
            en_seen_low <= 1'b0;
            digit_new   <= 4'h0;
            digit_old   <= 4'h0;
        end else begin
            en_q <= en;
            if (!en) en_seen_low <= 1'b1;
            if (capture) begin
                digit_old <= digit_new;
                digit_new <= key_to_hex(rc);
            end
        end
    end

`ifdef KEY_DISPLAY_BLANK_EN
    // Per-digit valid bits shift alongside the digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_new <= 1'b0;
            valid_old <= 1'b0;
        end else if (capture) begin
            valid_old <= valid_new;
            valid_new <= 1'b1;
        end
    end
`endif

    // Free-running multiplex divider; digit select flips on wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            sel     <= 1'b0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            if (div_cnt == '1) sel <= ~sel;
        end
    end

    // Registered digit drive; both digits dark around the select change to avoid ghosting.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 2'b11;
            seg <= SEG_BLANK;
        end else begin
            an  <= blank_win ? 2'b11 : (sel ? 2'b01 : 2'b10);
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_key_display_ctrl.sv
// Randomized scoreboard bench for key_display_ctrl (small divider for run time).
module tb_key_display_ctrl;

    localparam int DIV_W = 6;
    localparam int N     = 1 << DIV_W;

    localparam logic [6:0] TB_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rc = 8'h00;
    logic       en = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] digit_new;
    logic [3:0] digit_old;

    always #5 clk = ~clk;

    key_display_ctrl #(.DIV_W(DIV_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .rc        (rc),
        .en        (en),
        .seg       (seg),
        .an        (an),
        .digit_new (digit_new),
        .digit_old (digit_old)
    );

    typedef struct {
        int         due;
        logic [3:0] dn;
        logic [3:0] dold;
        string      name;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         passed = 0;
    int         cyc = 0;
    int         t = 0;
    logic [3:0] d_new = 4'h0;
    logic [3:0] d_old = 4'h0;
    bit         v_new = 1'b0;
    bit         v_old = 1'b0;
    bit         armed = 1'b0;
    logic [1:0] exp_an;
    logic [6:0] exp_seg;

    function automatic int find_one(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [6:0] digit_seg(input bit s);
`ifdef KEY_DISPLAY_BLANK_EN
        if (!(s ? v_old : v_new)) return 7'h7F;
`endif
        return TB_SEG[s ? d_old : d_new];
    endfunction

    // Display reference: t counts clocks since reset; phase and select follow from it.
    always @(posedge clk) begin : disp_model
        int ph;
        bit s;
        cyc <= cyc + 1;
        if (reset) begin
            t       <= 0;
            exp_an  <= 2'b11;
            exp_seg <= 7'h7F;
        end else begin
            ph = t % N;
            s  = ((t / N) % 2) == 1;
            t  <= t + 1;
            exp_an  <= (ph == N - 1 || ph < 4) ? 2'b11 : (s ? 2'b01 : 2'b10);
            exp_seg <= digit_seg(s);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Monitor: display every cycle, digit scoreboard entries when due.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            check("an", 32'(an), 32'(exp_an));
            if (exp_an != 2'b11) check("seg", 32'(seg), 32'(exp_seg));
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check({e.name, "_new"}, 32'(digit_new), 32'(e.dn));
                check({e.name, "_old"}, 32'(digit_old), 32'(e.dold));
            end
        end
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        d_new = 4'h0;
        d_old = 4'h0;
        v_new = 1'b0;
        v_old = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        armed = !en;
    endtask

    task automatic press(input logic [7:0] code, input int hold, input int gap, input bit rel);
        bit ok;
        @(negedge clk);
        rc = code;
        en = 1'b1;
        @(negedge clk);
        ok = armed && $countones(code[7:4]) == 1 && $countones(code[3:0]) == 1;
        if (ok) begin
            d_old = d_new;
            d_new = KEYMAP[find_one(code[7:4])][find_one(code[3:0])];
            v_old = v_new;
            v_new = 1'b1;
        end
        armed = 1'b0;
        sb.push_back(exp_t'{cyc, d_new, d_old, ok ? "capture" : "ignored"});
        if (hold > 1) begin
            repeat (hold - 1) @(negedge clk);
            sb.push_back(exp_t'{cyc, d_new, d_old, "hold"});
        end
        if (rel) begin
            en = 1'b0;
            rc = 8'($urandom);
            repeat (gap) @(negedge clk);
            armed = 1'b1;
        end
    endtask

    initial begin
        do_reset(3);
        repeat (4 * N + 10) @(negedge clk);

        press(8'h11, 1000, 3, 1'b1);
        press(8'h24, 5, 3, 1'b1);
        repeat (2 * N) @(negedge clk);
        press(8'h13, 4, 2, 1'b1);
        press(8'h31, 4, 2, 1'b1);
        press(8'h82, 3, 2, 1'b1);
        press(8'h88, 3, 2, 1'b1);

        press(8'h11, 3, 0, 1'b0);
        do_reset(3);
        repeat (5) @(negedge clk);
        sb.push_back(exp_t'{cyc, d_new, d_old, "held_reset"});
        en = 1'b0;
        repeat (2) @(negedge clk);
        armed = 1'b1;
        press(8'h18, 3, 2, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] code;
            if ($urandom_range(0, 3) != 0)
                code = 8'(1 << (4 + $urandom_range(0, 3))) | 8'(1 << $urandom_range(0, 3));
            else
                code = 8'($urandom);
            press(code, int'($urandom_range(1, 6)), int'($urandom_range(1, 4)), 1'b1);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, N)) @(negedge clk);
        end

        repeat (N + 4) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/key_display_ctrl.md
KEY_DISPLAY_CTRL -- requirements
Module: key_display_ctrl

Interface
REQ-001 Parameter DIV_W, default 17: width of the display-multiplex divider counter; at 48 MHz the digit select toggles about every 2.73 ms.
REQ-002 clk  input  1  system clock, 48 MHz HSOSC; the only clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rc  input  8  key code from the scanner; rc[4+r] one-hot row r, rc[c] one-hot column c.
REQ-005 en  input  1  key-valid level from the scanner; rc is stable while en is high.
REQ-006 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-007 an  output  2  digit enables, active-low; an[0] is the right (newest) digit, an[1] is the left (older) digit.
REQ-008 digit_new  output  4  most recently captured hex value.
REQ-009 digit_old  output  4  previously captured hex value.

Function
REQ-010 The block SHALL register en and capture only on its rising edge (en high, en_q low); holding en high SHALL NOT cause a repeated capture.
REQ-011 A capture SHALL occur only if rc[7:4] and rc[3:0] are each exactly one-hot; any other pattern on the capture edge SHALL be ignored.
REQ-012 The decode map, rows 0..3 by cols 0..3, SHALL be: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
REQ-013 On a capture, digit_old SHALL take digit_new and digit_new SHALL take the decoded value in the same edge; both outputs SHALL update one cycle after the rising edge of en is sampled.
REQ-014 A free-running DIV_W-bit counter SHALL toggle sel on wrap from all-ones to 0.
REQ-015 Anti-ghost rule: in the cycle sel toggles, and for counter values 0..3 after it, an SHALL be 2'b11; otherwise an SHALL be 2'b10 when sel=0 and 2'b01 when sel=1.
REQ-016 seg SHALL be the registered 7-segment pattern of digit_new when sel=0 and of digit_old when sel=1; the seg and an registers SHALL update on the same edge.
REQ-017 A capture coinciding with a sel toggle SHALL take effect normally; the display SHALL show the new values from the next lit phase.

Reset
REQ-018 While reset is high: counter=0, sel=0, en_q=0, digit_new=0, digit_old=0, an=2'b11, seg=7'h7F.
REQ-019 Reset asserted during a held key SHALL clear en_q; if en is still high at release, that SHALL NOT count as a rising edge until en has been seen low.

Configuration
REQ-020 Macro KEY_DISPLAY_BLANK_EN: when defined, each digit SHALL carry a valid bit, cleared by reset; a digit whose valid bit is 0 SHALL drive seg=7'h7F while lit.
REQ-021 On a capture with KEY_DISPLAY_BLANK_EN defined, valid_new SHALL be set and valid_old SHALL take the previous valid_new.
REQ-022 Without KEY_DISPLAY_BLANK_EN, no valid bits SHALL exist, and both digits SHALL display "0" after reset.

Structure
REQ-023 Package key_display_pkg SHALL hold the hex-to-segment constant table (16 x 7 bits), the blank constant 7'h7F, and the row/column to hex lookup.
REQ-024 A combinational sub-module seg_decode (4-bit hex in, 7-bit active-low segments out) SHALL be instantiated once, after the digit mux.

Verification
REQ-025 Reset, then run 2^DIV_W+10 cycles with en=0 -> an alternates 10/01 with 11 gaps; seg=7'h40 ("0") while lit; with the macro defined, seg=7'h7F.
REQ-026 Press rc=8'h11 with en held high for 1000 cycles -> digit_new=1 and digit_old=0 one cycle after the en rise; no further change while en is held.
REQ-027 Press rc=8'h11, release, then press rc=8'h24 -> digit_new=6 and digit_old=1; seg shows 7'h02 when an=10 and 7'h79 when an=01.
REQ-028 Press rc=8'h13 (two columns) or rc=8'h31 (two rows) -> no change to digit_new or digit_old.
REQ-029 Press rc=8'h82 (row3, col1) -> digit_new=0; then rc=8'h88 -> digit_new=D (4'hD) and digit_old=0.
REQ-030 Hold en high, assert reset for 3 cycles, release with en still high -> no capture; drop en, raise it again with rc=8'h18 -> digit_new=A.
